// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS core: fetch FSM states, reset vector,
// fetch exception encoding and stall vector bit positions.
package cpu_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] EXC_IF_ADEL      = 32'h0000_0001;

  localparam int STALL_INST = 0;
  localparam int STALL_ID   = 1;
  localparam int STALL_EXE  = 2;
  localparam int STALL_DATA = 3;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch producer: PC generation, single outstanding SRAM-like
// request, wrong-path return discard and misaligned-address reporting.
module inst_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic [3:0]   stall_i,
  input  logic         branch_enable_i,
  input  logic [31:0]  branch_target_i,
  input  logic         exception_i,
  input  logic [31:0]  exception_pc_i,
  output logic         inst_req_o,
  output logic [31:0]  inst_addr_o,
  input  logic         inst_addr_ok_i,
  input  logic         inst_data_ok_i,
  input  logic [31:0]  inst_rdata_i,
  output logic [31:0]  postif_pc_o,
  output logic [31:0]  postif_inst_o,
  output logic [31:0]  postif_exception_type_o,
  output logic         postif_inst_ren_o,
  output logic         postif_inst_ok_o,
  output logic         postif_inst_valid_o,
  output logic         inst_stall_req_o,
  output fetch_state_t state_dbg_o
);

  // Bus handshake: inst_req_o/inst_addr_o hold until a cycle with
  // inst_addr_ok_i (accept); exactly one inst_data_ok_i follows each accept,
  // possibly in the accept cycle itself.
  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  rpc_q, rpc_d;
  logic         rpend_q, rpend_d;
  logic         rexc_q, rexc_d;
  logic         adel_done_q, adel_done_d;
  logic [31:0]  opc_q, opc_d, oinst_q, oinst_d, oexc_q, oexc_d;
  logic         ook_q, ook_d, ovalid_q, ovalid_d;

  logic        stall_ok, redir_in, take_new, any_redir;
  logic [31:0] redir_tgt_in, merged_pc;
  logic        unused_stall_inst;

  assign unused_stall_inst = stall_i[STALL_INST];
  assign stall_ok     = (stall_i[STALL_DATA:STALL_ID] == 3'b000);
  assign redir_in     = exception_i | branch_enable_i;
  assign redir_tgt_in = exception_i ? exception_pc_i : branch_target_i;
  // A pending exception target is never replaced by a later branch.
  assign take_new     = redir_in && !(rpend_q && rexc_q && !exception_i);
  assign merged_pc    = take_new ? redir_tgt_in : rpc_q;
  assign any_redir    = rpend_q | redir_in;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      rpc_q       <= '0;
      rpend_q     <= 1'b0;
      rexc_q      <= 1'b0;
      adel_done_q <= 1'b0;
      opc_q       <= '0;
      oinst_q     <= '0;
      oexc_q      <= '0;
      ook_q       <= 1'b0;
      ovalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rpc_q       <= rpc_d;
      rpend_q     <= rpend_d;
      rexc_q      <= rexc_d;
      adel_done_q <= adel_done_d;
      opc_q       <= opc_d;
      oinst_q     <= oinst_d;
      oexc_q      <= oexc_d;
      ook_q       <= ook_d;
      ovalid_q    <= ovalid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rpc_d       = rpc_q;
    rpend_d     = rpend_q;
    rexc_d      = rexc_q;
    adel_done_d = adel_done_q;
    opc_d       = opc_q;
    oinst_d     = oinst_q;
    oexc_d      = oexc_q;
    ook_d       = 1'b0;
    ovalid_d    = ovalid_q;

    if (redir_in && state_q != ST_IDLE) begin
      rpend_d = 1'b1;
      rpc_d   = merged_pc;
      rexc_d  = take_new ? exception_i : rexc_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (redir_in) begin
          pc_d        = redir_tgt_in;
          adel_done_d = 1'b0;
        end else if (stall_ok) begin
          if (pc_q[1:0] != 2'b00) begin
            if (!adel_done_q) begin
              ook_d       = 1'b1;
              opc_d       = pc_q;
              oinst_d     = '0;
              oexc_d      = EXC_IF_ADEL;
              ovalid_d    = 1'b1;
              adel_done_d = 1'b1;
            end
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (inst_addr_ok_i) begin
          if (inst_data_ok_i) begin
            // A redirect seen before this cycle makes the return wrong-path.
            if (!rpend_q) begin
              ook_d    = 1'b1;
              opc_d    = pc_q;
              oinst_d  = inst_rdata_i;
              oexc_d   = '0;
              ovalid_d = !redir_in;
            end
            pc_d    = any_redir ? merged_pc : pc_q + 32'd4;
            state_d = ST_IDLE;
            rpend_d = 1'b0;
            rexc_d  = 1'b0;
          end else begin
            state_d = any_redir ? ST_DISCARD : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (inst_data_ok_i) begin
          ook_d    = 1'b1;
          opc_d    = pc_q;
          oinst_d  = inst_rdata_i;
          oexc_d   = '0;
          ovalid_d = !redir_in;
          pc_d     = redir_in ? redir_tgt_in : pc_q + 32'd4;
          state_d  = ST_IDLE;
          rpend_d  = 1'b0;
          rexc_d   = 1'b0;
        end else if (redir_in) begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (inst_data_ok_i) begin
          pc_d    = merged_pc;
          state_d = ST_IDLE;
          rpend_d = 1'b0;
          rexc_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (exception_i) begin
      ook_d    = 1'b0;
      opc_d    = '0;
      oinst_d  = '0;
      oexc_d   = '0;
      ovalid_d = 1'b0;
    end
  end

  assign inst_req_o              = (state_q == ST_REQ);
  assign inst_addr_o             = pc_q;
  assign postif_pc_o             = opc_q;
  assign postif_inst_o           = oinst_q;
  assign postif_exception_type_o = oexc_q;
  assign postif_inst_ok_o        = ook_q;
  assign postif_inst_valid_o     = ovalid_q;
  assign postif_inst_ren_o       = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign inst_stall_req_o        = (state_q != ST_IDLE);
  assign state_dbg_o             = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: bus responses driven step by step, expected
// deliveries queued when the returning data is driven and popped on inst_ok.
module tb_inst_fetch;
  import cpu_defs::*;

  localparam int W = 97;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   stall_i = '0;
  logic         branch_enable_i = 1'b0;
  logic [31:0]  branch_target_i = '0;
  logic         exception_i = 1'b0;
  logic [31:0]  exception_pc_i = '0;
  logic         inst_req_o;
  logic [31:0]  inst_addr_o;
  logic         inst_addr_ok_i = 1'b0;
  logic         inst_data_ok_i = 1'b0;
  logic [31:0]  inst_rdata_i = '0;
  logic [31:0]  postif_pc_o, postif_inst_o, postif_exception_type_o;
  logic         postif_inst_ren_o, postif_inst_ok_o, postif_inst_valid_o;
  logic         inst_stall_req_o;
  fetch_state_t state_dbg_o;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  inst_fetch dut (
    .clock_i                 (clk),
    .reset_i                 (rst_n),
    .stall_i                 (stall_i),
    .branch_enable_i         (branch_enable_i),
    .branch_target_i         (branch_target_i),
    .exception_i             (exception_i),
    .exception_pc_i          (exception_pc_i),
    .inst_req_o              (inst_req_o),
    .inst_addr_o             (inst_addr_o),
    .inst_addr_ok_i          (inst_addr_ok_i),
    .inst_data_ok_i          (inst_data_ok_i),
    .inst_rdata_i            (inst_rdata_i),
    .postif_pc_o             (postif_pc_o),
    .postif_inst_o           (postif_inst_o),
    .postif_exception_type_o (postif_exception_type_o),
    .postif_inst_ren_o       (postif_inst_ren_o),
    .postif_inst_ok_o        (postif_inst_ok_o),
    .postif_inst_valid_o     (postif_inst_valid_o),
    .inst_stall_req_o        (inst_stall_req_o),
    .state_dbg_o             (state_dbg_o)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst,
                      input logic [31:0] exc, input logic valid);
    exp_q.push_back({pc, inst, exc, valid});
  endtask

  // One clock: present read data for the current address, sample #1 after
  // the edge and score any delivery strobe against the expected queue.
  task automatic tick(input string tag);
    logic [W-1:0] e;
    inst_rdata_i = rd(inst_addr_o);
    @(posedge clk);
    #1;
    if (postif_inst_ok_o) begin
      check({tag, ":strobe_expected"}, {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({tag, ":pc"},    postif_pc_o,             e[96:65]);
        check({tag, ":inst"},  postif_inst_o,           e[64:33]);
        check({tag, ":exc"},   postif_exception_type_o, e[32:1]);
        check({tag, ":valid"}, {31'b0, postif_inst_valid_o}, {31'b0, e[0]});
      end
    end
  endtask

  task automatic drained(input string tag);
    check({tag, ":sb_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    // Reset, with the bus already answering every request immediately.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",   {31'b0, inst_req_o}, 32'd0);
    check("rst_addr",  inst_addr_o, 32'hBFC0_0000);
    check("rst_ok",    {31'b0, postif_inst_ok_o}, 32'd0);
    check("rst_valid", {31'b0, postif_inst_valid_o}, 32'd0);
    check("rst_pc",    postif_pc_o, 32'd0);
    check("rst_state", {30'b0, state_dbg_o}, {30'b0, ST_IDLE});
    rst_n = 1'b1;
    inst_addr_ok_i = 1'b1;
    inst_data_ok_i = 1'b1;

    tick("c1");
    check("c1_req",  {31'b0, inst_req_o}, 32'd1);
    check("c1_addr", inst_addr_o, 32'hBFC0_0000);
    push(32'hBFC0_0000, rd(32'hBFC0_0000), 32'd0, 1'b1);
    tick("c2");
    drained("c2");
    check("c2_req",  {31'b0, inst_req_o}, 32'd0);
    tick("c3");
    check("c3_req",  {31'b0, inst_req_o}, 32'd1);
    check("c3_addr", inst_addr_o, 32'hBFC0_0004);

    // Accept without data, branch while waiting, data 5 cycles after accept.
    inst_data_ok_i = 1'b0;
    tick("wait1");
    check("wait_stall", {31'b0, inst_stall_req_o}, 32'd1);
    check("wait_ren",   {31'b0, postif_inst_ren_o}, 32'd1);
    check("wait_req",   {31'b0, inst_req_o}, 32'd0);
    inst_addr_ok_i = 1'b0;
    tick("wait2");
    branch_enable_i = 1'b1;
    branch_target_i = 32'h8000_0100;
    tick("br");
    branch_enable_i = 1'b0;
    check("disc_state", {30'b0, state_dbg_o}, {30'b0, ST_DISCARD});
    check("disc_ren",   {31'b0, postif_inst_ren_o}, 32'd0);
    check("disc_stall", {31'b0, inst_stall_req_o}, 32'd1);
    tick("disc1");
    tick("disc2");
    inst_data_ok_i = 1'b1;
    tick("drop");
    inst_data_ok_i = 1'b0;
    check("drop_addr",  inst_addr_o, 32'h8000_0100);
    check("drop_req",   {31'b0, inst_req_o}, 32'd0);
    tick("br_issue");
    check("br_req",  {31'b0, inst_req_o}, 32'd1);
    check("br_addr", inst_addr_o, 32'h8000_0100);

    // Deliver, then simultaneous exception and branch while idle.
    inst_addr_ok_i = 1'b1;
    inst_data_ok_i = 1'b1;
    push(32'h8000_0100, rd(32'h8000_0100), 32'd0, 1'b1);
    tick("d100");
    drained("d100");
    exception_i     = 1'b1;
    exception_pc_i  = 32'hBFC0_0380;
    branch_enable_i = 1'b1;
    branch_target_i = 32'h8000_0000;
    tick("exc_br");
    exception_i     = 1'b0;
    branch_enable_i = 1'b0;
    check("exc_clr_pc",    postif_pc_o, 32'd0);
    check("exc_clr_inst",  postif_inst_o, 32'd0);
    check("exc_clr_valid", {31'b0, postif_inst_valid_o}, 32'd0);
    tick("exc_issue");
    check("exc_req",  {31'b0, inst_req_o}, 32'd1);
    check("exc_addr", inst_addr_o, 32'hBFC0_0380);

    // Branch in the delivery cycle to a misaligned target.
    branch_enable_i = 1'b1;
    branch_target_i = 32'h8000_0102;
    push(32'hBFC0_0380, rd(32'hBFC0_0380), 32'd0, 1'b0);
    tick("br_dlv");
    branch_enable_i = 1'b0;
    drained("br_dlv");
    check("mis_addr", inst_addr_o, 32'h8000_0102);
    push(32'h8000_0102, 32'd0, EXC_IF_ADEL, 1'b1);
    tick("adel");
    drained("adel");
    check("adel_req", {31'b0, inst_req_o}, 32'd0);
    tick("adel_hold");
    check("adel_hold_req", {31'b0, inst_req_o}, 32'd0);
    check("adel_hold_ok",  {31'b0, postif_inst_ok_o}, 32'd0);

    // Redirect to the top of memory under an execute stall held 4 cycles.
    stall_i         = 4'b0100;
    branch_enable_i = 1'b1;
    branch_target_i = 32'hFFFF_FFFC;
    tick("st0");
    branch_enable_i = 1'b0;
    check("st0_req", {31'b0, inst_req_o}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick("stall");
      check("stall_req", {31'b0, inst_req_o}, 32'd0);
    end
    stall_i = 4'b0000;
    tick("unstall");
    check("unstall_req",  {31'b0, inst_req_o}, 32'd1);
    check("unstall_addr", inst_addr_o, 32'hFFFF_FFFC);

    // Wrap-around fetch through WAIT.
    inst_data_ok_i = 1'b0;
    tick("wrap_acc");
    inst_addr_ok_i = 1'b0;
    inst_data_ok_i = 1'b1;
    push(32'hFFFF_FFFC, rd(32'hFFFF_FFFC), 32'd0, 1'b1);
    tick("wrap_dlv");
    drained("wrap_dlv");
    inst_data_ok_i = 1'b0;
    check("wrap_addr", inst_addr_o, 32'h0000_0000);
    tick("wrap_issue");
    check("wrap_req", {31'b0, inst_req_o}, 32'd1);

    // Exception before accept, then a branch that must not override it.
    exception_i    = 1'b1;
    exception_pc_i = 32'hBFC0_0380;
    tick("pend_exc");
    exception_i = 1'b0;
    check("pend_req",  {31'b0, inst_req_o}, 32'd1);
    check("pend_addr", inst_addr_o, 32'h0000_0000);
    branch_enable_i = 1'b1;
    branch_target_i = 32'h8000_0000;
    inst_addr_ok_i  = 1'b1;
    tick("pend_acc");
    branch_enable_i = 1'b0;
    inst_addr_ok_i  = 1'b0;
    check("pend_state", {30'b0, state_dbg_o}, {30'b0, ST_DISCARD});
    inst_data_ok_i = 1'b1;
    tick("pend_drop");
    inst_data_ok_i = 1'b0;
    check("pend_tgt", inst_addr_o, 32'hBFC0_0380);
    tick("pend_issue");
    check("pend_req2", {31'b0, inst_req_o}, 32'd1);

    // Asynchronous reset in the middle of a request.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req",   {31'b0, inst_req_o}, 32'd0);
    check("arst_addr",  inst_addr_o, 32'hBFC0_0000);
    check("arst_state", {30'b0, state_dbg_o}, {30'b0, ST_IDLE});
    drained("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch producer for the five-stage MIPS core. It drives the postif→ID pipeline register's fetch-side inputs: it generates the PC, issues SRAM-like requests to the instruction bus bridge and tracks the single outstanding request. It discards wrong-path returns after branch or exception redirects and flags misaligned fetch addresses. It sits between the hazard/stall unit and the postif_id register, and is the sending end of the postif_* interface.

## Interface
- RESET_PC, 32'hBFC0_0000, first fetch address after reset
- clock_i  in  1  core clock
- reset_i  in  1  asynchronous, active-low reset
- stall_i  in  4  [0] inst, [1] id, [2] exe, [3] data stall (same encoding as postif_id)
- branch_enable_i  in  1  one-cycle redirect pulse; delay slot already delivered
- branch_target_i  in  32  redirect target, valid with branch_enable_i
- exception_i  in  1  one-cycle flush pulse
- exception_pc_i  in  32  handler entry, valid with exception_i
- inst_req_o  out  1  bus request
- inst_addr_o  out  32  request address (= pc register)
- inst_addr_ok_i  in  1  request accepted
- inst_data_ok_i  in  1  read data valid
- inst_rdata_i  in  32  read data
- postif_pc_o  out  32  PC of delivered instruction
- postif_inst_o  out  32  delivered instruction word
- postif_exception_type_o  out  32  fetch exception bits
- postif_inst_ren_o  out  1  request outstanding (state REQ or WAIT)
- postif_inst_ok_o  out  1  one-cycle delivery strobe
- postif_inst_valid_o  out  1  delivered instruction is on the correct path
- inst_stall_req_o  out  1  to hazard unit; 1 in REQ, WAIT, DISCARD

## Operation
- States: IDLE, REQ, WAIT, DISCARD. Reset state is IDLE, pc = RESET_PC, redirect_pending = 0. All postif_* outputs and inst_req_o reset to 0.
- IDLE → REQ when stall_i[3:1] == 0, pc[1:0] == 0, and no redirect is pending. IDLE holds otherwise.
- IDLE with pc[1:0] != 0: no bus request is issued. Next cycle the block delivers postif_inst_o = 0, postif_pc_o = pc, postif_exception_type_o = EXC_IF_ADEL (bit 0), and inst_ok = valid = 1. The block then stays IDLE until a redirect arrives.
- REQ: inst_req_o = 1. inst_addr_o stays stable until inst_addr_ok_i.
  - addr_ok without data_ok → WAIT.
  - addr_ok with data_ok in the same cycle → deliver, then IDLE.
- WAIT: on inst_data_ok_i → deliver and go IDLE. pc ← pc + 4, with 32-bit wrap-around.
- Deliver means one registered cycle of: postif_inst_ok_o = 1, postif_pc_o = request pc, postif_inst_o = inst_rdata_i, exception_type = 0, valid = 1.
- Redirect (exception_i or branch_enable_i) captures its target into redirect_pc and sets redirect_pending. Exception has priority when both occur in the same cycle.
  - In IDLE: pc ← target directly; no pending state.
  - In REQ before addr_ok: keep the request. On addr_ok go DISCARD (same-cycle data_ok: drop the data, apply the target, go IDLE).
  - In WAIT: go DISCARD.
  - In DISCARD: a newer redirect overwrites redirect_pc; exception overwrites branch, branch never overwrites exception.
- DISCARD: wait for data_ok, drop the data with no inst_ok strobe, then pc ← redirect_pc and go IDLE.
- If a redirect arrives in the same cycle as delivery, the instruction is still strobed but with postif_inst_valid_o = 0.
- exception_i additionally clears postif_* outputs to 0 next cycle.
- Stalls never abort an accepted request. At most one delivery lands while stall_i[3:1] != 0, because no new issue starts while stalled; postif_id buffers that one delivery.

## Timing
- At most one outstanding request.
- Best case: IDLE (c0) → REQ (c1, addr_ok + data_ok) → inst_ok (c2) → REQ (c3). Throughput is 1 instruction per 2 cycles.
- Delivery strobe comes 1 cycle after data_ok.
- Redirect target reaches inst_addr_o no later than 1 cycle after the pending return is dropped.
- Asynchronous reset mid-transaction forces IDLE immediately. The bus bridge shares reset_i, so no stale data_ok follows.

## Structure
- Shared package cpu_defs holds:
  - fetch_state_t enum
  - RESET_PC default
  - EXC_IF_ADEL = 32'h0000_0001
  - stall bit indices STALL_INST/ID/EXE/DATA = 0..3
- Single module, no sub-module: one FSM, a pc register and a redirect register.

## Test plan
- Reset release with addr_ok and data_ok tied 1 → first inst_req_o at c1 with addr BFC0_0000; inst_ok at c2 with pc BFC0_0000; next request addr BFC0_0004.
- data_ok delayed 5 cycles, branch_enable_i at WAIT cycle 2 with target 8000_0100 → return dropped with no inst_ok; next inst_addr_o = 8000_0100.
- exception_i and branch_enable_i in the same cycle (targets BFC0_0380 / 8000_0000) → next fetch at BFC0_0380; postif_* cleared to 0.
- Branch target 8000_0102 → no bus request; inst_ok = 1, pc = 8000_0102, exception_type = 1, inst = 0.
- stall_i = 4'b0100 held 4 cycles while in IDLE → inst_req_o stays 0; issue occurs the cycle after the stall drops.
- pc = FFFF_FFFC fetch completes → next inst_addr_o = 0000_0000.
